// File: rtl/ray_frame_scheduler.sv
// Frame-level sequencer for the ray-marching datapath: double-buffers the config block,
// walks pixel coordinates over a valid/ready handshake and paces frames on drain reports.
module ray_frame_scheduler #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int XW        = 10,
  parameter int YW        = 9,
  parameter int CFG_WORDS = 8
) (
  input  logic                    out_stream_aclk,
  input  logic                    periph_resetn,
  input  logic [32*CFG_WORDS-1:0] cfg_in,
  input  logic                    cfg_commit,
  input  logic                    ctrl_enable,
  input  logic                    ctrl_single,
  input  logic                    frame_end_in,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [XW-1:0]           pix_x,
  output logic [YW-1:0]           pix_y,
  output logic                    pix_sof,
  output logic                    pix_eol,
  output logic [32*CFG_WORDS-1:0] cfg_active,
  output logic                    cfg_pending,
  output logic                    busy,
  output logic                    frame_done,
  output logic [15:0]             frame_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  state_t                    state_q;
  state_t                    state_d;
  logic                      single_q;
  logic [32*CFG_WORDS-1:0]   shadow_q;
  logic                      beat;
  logic                      last_beat;
  logic                      start_req;
  logic                      drain_done;

  assign beat       = pix_valid && pix_ready;
  assign last_beat  = beat && (pix_x == X_LAST) && (pix_y == Y_LAST);
  assign start_req  = ctrl_enable || ctrl_single;
  assign drain_done = (state_q == ST_DRAIN) && frame_end_in;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours regardless of process ordering.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pix_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start_req) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        pix_valid = 1'b1;
        if (last_beat) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (frame_end_in) state_d = (ctrl_enable && !single_q) ? ST_LOAD : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Tags are derived from the held payload, so they stay coherent with pix_x/pix_y during stalls.
  assign pix_sof = pix_valid && (pix_x == '0) && (pix_y == '0);
  assign pix_eol = pix_valid && (pix_x == X_LAST);

  // Single-frame mode is only latched when a frame starts from IDLE without ctrl_enable.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      single_q <= 1'b0;
    end else if (state_q == ST_IDLE && start_req) begin
      single_q <= !ctrl_enable;
    end else if (drain_done) begin
      single_q <= 1'b0;
    end
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      pix_x <= '0;
      pix_y <= '0;
    end else if (state_q == ST_LOAD) begin
      pix_x <= '0;
      pix_y <= '0;
    end else if (beat) begin
      if (pix_x == X_LAST) begin
        pix_x <= '0;
        pix_y <= (pix_y == Y_LAST) ? '0 : pix_y + YW'(1);
      end else begin
        pix_x <= pix_x + XW'(1);
      end
    end
  end

  // A commit landing in the LOAD cycle wins over the clear, so it rolls to the next frame.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      shadow_q    <= '0;
      cfg_pending <= 1'b0;
      cfg_active  <= '0;
    end else begin
      if (cfg_commit) shadow_q <= cfg_in;
      if (cfg_commit) begin
        cfg_pending <= 1'b1;
      end else if (state_q == ST_LOAD) begin
        cfg_pending <= 1'b0;
      end
      if (state_q == ST_LOAD && cfg_pending) cfg_active <= shadow_q;
    end
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= drain_done;
      if (drain_done) frame_count <= frame_count + 16'd1;
    end
  end

endmodule
